// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format select and occupancy state.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_ILL = 3'b111
  } imm_fmt_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int INSTR_W = 32;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction/extension for every RV32I/RV64I format plus zimm and shamt.
// Zero latency; illegal selects return imm=0 with err=1.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input  logic [INSTR_W-1:0] In,
  input  logic [2:0]         ImmSrc,
  output logic [XLEN-1:0]    imm,
  output logic               err
);

  logic [31:0] w_raw;
  logic        w_sext;
  logic        w_unused;

  // Opcode bits never contribute to any immediate.
  assign w_unused = ^In[6:0];

  always_comb begin
    w_raw  = 32'b0;
    w_sext = 1'b0;
    err    = 1'b0;
    case (imm_fmt_t'(ImmSrc))
      IMM_I: begin
        w_raw  = {{20{In[31]}}, In[31:20]};
        w_sext = 1'b1;
      end
      IMM_S: begin
        w_raw  = {{20{In[31]}}, In[31:25], In[11:7]};
        w_sext = 1'b1;
      end
      IMM_B: begin
        w_raw  = {{19{In[31]}}, In[31], In[7], In[30:25], In[11:8], 1'b0};
        w_sext = 1'b1;
      end
      IMM_J: begin
        w_raw  = {{11{In[31]}}, In[31], In[19:12], In[20], In[30:21], 1'b0};
        w_sext = 1'b1;
      end
      IMM_U: begin
        w_raw  = {In[31:12], 12'b0};
        w_sext = 1'b1;
      end
      IMM_Z: begin
        if (ZIMM_EN) w_raw = {27'b0, In[19:15]};
        else         err   = 1'b1;
      end
      IMM_SH: begin
        if (XLEN == 64) w_raw = {26'b0, In[25:20]};
        else            w_raw = {27'b0, In[24:20]};
      end
      default: err = 1'b1;
    endcase
  end

  // Upper half only matters for XLEN=64; the cast drops it for XLEN=32.
  assign imm = XLEN'({{32{w_sext & w_raw[31]}}, w_raw});

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready and a 2-entry skid; 1-cycle latency.
// in_ready is registered (skid empty), so back-pressure never drops or reorders instructions.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] In,
  input  logic [2:0]         ImmSrc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    Imm_Ext,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  occ_t             r_state;
  occ_t             w_state_nxt;
  logic             r_in_rdy;
  logic [XLEN-1:0]  r_imm,   r_s_imm;
  logic [TAG_W-1:0] r_tag,   r_s_tag;
  logic             r_err,   r_s_err;

  logic [XLEN-1:0]  w_imm;
  logic             w_err;
  logic             w_acc;
  logic             w_pop;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_skid_mv;

  imm_extract #(
    .XLEN    (XLEN),
    .ZIMM_EN (ZIMM_EN)
  ) u_extract (
    .In     (In),
    .ImmSrc (ImmSrc),
    .imm    (w_imm),
    .err    (w_err)
  );

  // Flush beats a same-cycle accept.
  assign w_acc = in_valid & r_in_rdy & ~flush;
  assign w_pop = (r_state != OCC_EMPTY) & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= OCC_EMPTY;
      r_in_rdy <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_in_rdy <= (w_state_nxt != OCC_TWO);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: if (w_acc) w_state_nxt = OCC_ONE;
        OCC_ONE: begin
          if (w_acc && !w_pop)      w_state_nxt = OCC_TWO;
          else if (!w_acc && w_pop) w_state_nxt = OCC_EMPTY;
        end
        OCC_TWO:   if (w_pop) w_state_nxt = OCC_ONE;
        default:   w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_load_out  = 1'b0;
    w_load_skid = 1'b0;
    w_skid_mv   = 1'b0;
    case (r_state)
      OCC_EMPTY: w_load_out = w_acc;
      OCC_ONE: begin
        w_load_out  = w_acc & w_pop;
        w_load_skid = w_acc & ~w_pop;
      end
      OCC_TWO:   w_skid_mv = w_pop & ~flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_imm <= '0;
      r_tag <= '0;
      r_err <= 1'b0;
    end else if (w_load_out) begin
      r_imm <= w_imm;
      r_tag <= in_tag;
      r_err <= w_err;
    end else if (w_skid_mv) begin
      r_imm <= r_s_imm;
      r_tag <= r_s_tag;
      r_err <= r_s_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_imm <= '0;
      r_s_tag <= '0;
      r_s_err <= 1'b0;
    end else if (w_load_skid) begin
      r_s_imm <= w_imm;
      r_s_tag <= in_tag;
      r_s_err <= w_err;
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = (r_state != OCC_EMPTY);
  assign Imm_Ext   = r_imm;
  assign out_tag   = r_tag;
  assign out_err   = r_err;

endmodule
